shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit D-type register that N_REQ requesters update.
- Each requester holds a request with its data. The block grants one requester at a time, commits its data into the register and returns a one-cycle acknowledge.
- Sits between the requesting blocks and the shared flop bank. It is the only writer of that register.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, width of the shared register and of each write-data slice.
- COUNT_W, 16, width of the committed-write counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous reset, active-high.
- req  input  N_REQ  per-requester write request, level.
- wdata  input  N_REQ*WIDTH  per-requester write data; slice i is bits [i*WIDTH +: WIDTH].
- clr  input  1  synchronous clear of the shared register, active-high.
- grant  output  N_REQ  one-hot grant, registered.
- ack  output  N_REQ  one-hot one-cycle write-committed pulse, registered.
- q  output  WIDTH  shared register value.
- q_valid  output  1  q holds committed data (not cleared since last write).
- owner  output  clog2(N_REQ)  index of the last committed writer.
- write_count  output  COUNT_W  saturating count of committed writes.

Behaviour:
- Reset has priority over everything.
  - While reset=1 at an edge, the next state is IDLE.
  - Output reset values: grant=0, ack=0, q=0, q_valid=0, owner=0, write_count=0.
  - The round-robin pointer resets to N_REQ-1, so the first search starts at index 0.
  - Reset asserted in any state aborts the operation: no ack and no q update.
- FSM states:
  - IDLE: if req!=0, select an index and go to WRITE; otherwise stay in IDLE.
  - WRITE: grant is asserted; always goes to ACK.
  - ACK: ack is asserted; always goes to IDLE.
- Selection: the first set req bit searching from ptr+1 upward, modulo N_REQ. The chosen index is registered as sel, and ptr<=sel at the commit.
- Cycle timing (req first seen in IDLE at edge t):
  - Cycle t+1: state WRITE, grant[sel]=1. At the end of t+1, q<=wdata[sel], owner<=sel, q_valid<=1, write_count<=sat(write_count+1).
  - Cycle t+2: state ACK, ack[sel]=1, new q visible, grant=0.
  - Cycle t+3: IDLE, arbitration again.
- Latency from req to ack is 2 cycles. Peak throughput is one write per 3 cycles.
- Requester rule: hold req and wdata stable until ack, and deassert req in the cycle following ack. req still high when IDLE samples it is treated as a new request.
- wdata is sampled only in the WRITE cycle. A req dropped during WRITE does not cancel the write; it commits and ack still pulses.
- clr:
  - In any non-commit cycle, clr=1 sets q<=0 and q_valid<=0.
  - Coincident with the WRITE commit, clr wins: q<=0, q_valid<=0, owner unchanged, write_count unchanged. ack still pulses in ACK and ptr still advances.
  - clr does not change the FSM state.
- write_count saturates at 2^COUNT_W-1 and never wraps.
- grant and ack are each at most one-hot and never high in the same cycle.
- Requests arriving during WRITE or ACK wait for the next IDLE. No request is lost while its req is held.

Test Plan:
- Single write (N_REQ=4, WIDTH=8): after reset, req=4'b0100 with wdata slice 2=0xA5.
  -> grant=0100 at t+1; q=0xA5 and ack=0100 at t+2; owner=2, q_valid=1, write_count=1.
- Fairness: req=4'b1111 held high, each requester dropping req after its ack and re-raising it one cycle later.
  -> grant order 0,1,2,3,0,1; one ack every 3 cycles; write_count=6 after 6 acks.
- Pointer wrap: last owner=3, then req=4'b1001.
  -> index 0 is granted first, then 3.
- clr collision: clr=1 in the WRITE cycle for req[1] with data 0x3C.
  -> q=0x00, q_valid=0, ack[1] pulses, write_count unchanged, owner unchanged.
- Reset mid-operation: reset=1 during WRITE.
  -> next cycle grant=0, ack=0, q=0, write_count=0, state IDLE; no ack ever issued for that request.
- Saturation: COUNT_W=2, 5 consecutive single-requester writes.
  -> write_count reads 1,2,3,3,3; q tracks each written value.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// One requester is granted, its data committed, then acknowledged; IDLE -> WRITE -> ACK.
module shared_reg_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16,
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    input  logic                     clr,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [IDX_W-1:0]         owner,
    output logic [COUNT_W-1:0]       write_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   sel_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   ack_q;
    logic [WIDTH-1:0]   data_q;
    logic               valid_q;
    logic [IDX_W-1:0]   owner_q;
    logic [COUNT_W-1:0] count_q;

    logic [IDX_W-1:0]   sel_d;
    logic [WIDTH-1:0]   wdata_sel_s;
    logic [COUNT_W-1:0] count_d;

    // First set request strictly after the pointer, wrapping modulo N_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        logic             found;
        cand  = p;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (cand == IDX_W'(N_REQ - 1)) begin
                cand = {IDX_W{1'b0}};
            end else begin
                cand = cand + IDX_W'(1);
            end
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic logic [WIDTH-1:0] slice_of(input logic [N_REQ*WIDTH-1:0] d,
                                                  input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] s;
        s = {WIDTH{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                s = d[i*WIDTH +: WIDTH];
            end
        end
        return s;
    endfunction

    // Next selection, selected write data and saturating count increment.
    always_comb begin
        sel_d       = rr_pick(req, ptr_q);
        wdata_sel_s = slice_of(wdata, sel_q);
        if (count_q == {COUNT_W{1'b1}}) begin
            count_d = count_q;
        end else begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    // Sequencer FSM with registered grant/ack and the shared register itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            sel_q   <= {IDX_W{1'b0}};
            grant_q <= {N_REQ{1'b0}};
            ack_q   <= {N_REQ{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            owner_q <= {IDX_W{1'b0}};
            count_q <= {COUNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= {N_REQ{1'b0}};
                    if (|req) begin
                        sel_q   <= sel_d;
                        grant_q <= onehot(sel_d);
                        state_q <= ST_WRITE;
                    end else begin
                        grant_q <= {N_REQ{1'b0}};
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    grant_q <= {N_REQ{1'b0}};
                    ack_q   <= onehot(sel_q);
                    ptr_q   <= sel_q;
                    state_q <= ST_ACK;
                    // A coincident clear wins over the commit but the handshake completes.
                    if (clr) begin
                        data_q  <= {WIDTH{1'b0}};
                        valid_q <= 1'b0;
                    end else begin
                        data_q  <= wdata_sel_s;
                        valid_q <= 1'b1;
                        owner_q <= sel_q;
                        count_q <= count_d;
                    end
                end
                ST_ACK: begin
                    grant_q <= {N_REQ{1'b0}};
                    ack_q   <= {N_REQ{1'b0}};
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= {N_REQ{1'b0}};
                    ack_q   <= {N_REQ{1'b0}};
                    state_q <= ST_IDLE;
                end
            endcase
            if (clr && (state_q != ST_WRITE)) begin
                data_q  <= {WIDTH{1'b0}};
                valid_q <= 1'b0;
            end
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign q           = data_q;
    assign q_valid     = valid_q;
    assign owner       = owner_q;
    assign write_count = count_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter: default instance plus a
// COUNT_W=2 instance sharing the same stimulus for the saturation case.
module tb_shared_reg_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        clr;

    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic        q_valid;
    logic [1:0]  owner;
    logic [15:0] write_count;

    logic [3:0]  s_grant;
    logic [3:0]  s_ack;
    logic [7:0]  s_q;
    logic        s_q_valid;
    logic [1:0]  s_owner;
    logic [1:0]  s_write_count;

    int n_checks;
    int n_pass;

    shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .clr(clr),
        .grant(grant), .ack(ack), .q(q), .q_valid(q_valid),
        .owner(owner), .write_count(write_count)
    );

    shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .COUNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata), .clr(clr),
        .grant(s_grant), .ack(s_ack), .q(s_q), .q_valid(s_q_valid),
        .owner(s_owner), .write_count(s_write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int prev;
        int e;
        logic [7:0] d;
        logic [3:0] oh;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1;
        req   = 4'b0000;
        wdata = 32'h0000_0000;
        clr   = 1'b0;
        step();
        step();
        check_eq("rst_grant", grant, 4'b0000);
        check_eq("rst_ack", ack, 4'b0000);
        check_eq("rst_q", q, 8'h00);
        check_eq("rst_valid", q_valid, 1'b0);
        check_eq("rst_owner", owner, 2'd0);
        check_eq("rst_count", write_count, 16'd0);
        reset = 1'b0;
        step();

        // Single write from requester 2
        req = 4'b0100;
        wdata[23:16] = 8'hA5;
        step();
        check_eq("single_grant", grant, 4'b0100);
        check_eq("single_ack_early", ack, 4'b0000);
        step();
        check_eq("single_ack", ack, 4'b0100);
        check_eq("single_grant_off", grant, 4'b0000);
        check_eq("single_q", q, 8'hA5);
        check_eq("single_owner", owner, 2'd2);
        check_eq("single_valid", q_valid, 1'b1);
        check_eq("single_count", write_count, 16'd1);
        step();
        req = 4'b0000;
        check_eq("single_ack_off", ack, 4'b0000);

        // Fairness from a fresh reset with all four requesting
        reset = 1'b1;
        step();
        reset = 1'b0;
        wdata = 32'h44_33_22_11;
        req   = 4'b1111;
        prev  = -1;
        for (int k = 0; k < 6; k++) begin
            e  = k % 4;
            oh = 4'b0001 << e;
            step();
            if (prev >= 0) req[prev] = 1'b1;
            check_eq("fair_grant", grant, oh);
            step();
            check_eq("fair_ack", ack, oh);
            check_eq("fair_q", q, 8'h11 * (e + 1));
            check_eq("fair_count", write_count, k + 1);
            step();
            req[e] = 1'b0;
            prev   = e;
        end
        req = 4'b0000;

        // Owner 3, then 0 and 3 requesting: pointer wraps to 0 first
        req = 4'b1000;
        wdata[31:24] = 8'hC3;
        step();
        check_eq("wrap_pre_grant", grant, 4'b1000);
        step();
        check_eq("wrap_pre_owner", owner, 2'd3);
        step();
        req = 4'b1001;
        wdata[7:0] = 8'h5A;
        step();
        check_eq("wrap_grant0", grant, 4'b0001);
        step();
        check_eq("wrap_ack0", ack, 4'b0001);
        check_eq("wrap_q0", q, 8'h5A);
        step();
        req = 4'b1000;
        step();
        check_eq("wrap_grant3", grant, 4'b1000);
        step();
        check_eq("wrap_ack3", ack, 4'b1000);
        check_eq("wrap_q3", q, 8'hC3);
        check_eq("wrap_count", write_count, 16'd9);
        step();
        req = 4'b0000;
        step();

        // clr coincident with the commit of requester 1
        req = 4'b0010;
        wdata[15:8] = 8'h3C;
        step();
        check_eq("clr_grant", grant, 4'b0010);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("clr_ack", ack, 4'b0010);
        check_eq("clr_q", q, 8'h00);
        check_eq("clr_valid", q_valid, 1'b0);
        check_eq("clr_count", write_count, 16'd9);
        check_eq("clr_owner", owner, 2'd3);
        step();
        req = 4'b0000;
        step();

        // Pointer must have advanced to 1 despite the clear: 2 beats 1
        req = 4'b0110;
        step();
        check_eq("ptr_after_clr", grant, 4'b0100);
        step();
        check_eq("ptr_after_clr_q", q, 8'h33);
        check_eq("ptr_after_clr_count", write_count, 16'd10);
        step();
        req = 4'b0000;

        // clr in a non-commit cycle
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("idle_clr_q", q, 8'h00);
        check_eq("idle_clr_valid", q_valid, 1'b0);
        check_eq("idle_clr_count", write_count, 16'd10);

        // Reset during WRITE aborts the request
        req = 4'b0001;
        step();
        check_eq("midrst_grant_pre", grant, 4'b0001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0000;
        check_eq("midrst_grant", grant, 4'b0000);
        check_eq("midrst_ack", ack, 4'b0000);
        check_eq("midrst_q", q, 8'h00);
        check_eq("midrst_count", write_count, 16'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("midrst_no_ack", ack, 4'b0000);
        end

        // Saturation with COUNT_W=2: back-to-back writes from requester 2
        for (int k = 0; k < 5; k++) begin
            d = 8'h10 * (k + 1) + k;
            req = 4'b0100;
            wdata[23:16] = d;
            step();
            step();
            check_eq("sat_count", s_write_count, (k < 3) ? (k + 1) : 3);
            check_eq("sat_q", s_q, d);
            check_eq("sat_main_count", write_count, k + 1);
            step();
        end
        req = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
